systolic_data_setup: RTL and testbench

- Upstream feeder for the matrix multiply unit's systolic array; accepts one input vector and one weight vector per handshake.
- Applies diagonal skew (lane i delayed i cycles) so operands meet in the correct PE, and sequences a tile: clear, stream, flush, done.
- Its outputs drive the array's Inputs, Weights, EN and SYNC_RST directly.

---
 rtl/systolic_data_setup.sv | 234 +++++++++++++++++++++++
 tb/tb_systolic_data_setup.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_data_setup.sv
// systolic_data_setup
//   Feeder for the matrix-multiply systolic array. Takes one input vector
//   and one weight vector per handshake and skews them diagonally, so that
//   lane i is delayed i cycles. It also runs each tile through the sequence
//   clear -> stream -> flush -> done.
//
// Ports
//   CLK, ASYNC_RST       clock (rising edge), async active-low reset
//   SYNC_RST             synchronous clear, overrides every other input
//   START, TILE_K        begin a tile of TILE_K vectors (sampled in IDLE only)
//   IN_VALID, IN_READY   vector handshake
//   IN_VEC, W_VEC        input / weight vectors, lane i -> array row / column i
//   MMU_INPUTS/WEIGHTS   skewed operands to the array
//   MMU_EN, MMU_CLR      array enable / synchronous clear
//   BUSY, DONE           tile in progress / one-cycle "results final" pulse
//   STALL_CNT            (only with DATA_SETUP_STALL_CNT_EN) saturating count
//                        of STREAM cycles in which IN_VALID was low
//
// Optional feature macro: DATA_SETUP_STALL_CNT_EN
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for START with a non-zero TILE_K
// CLEAR   | one cycle: clear the array and zero the skew registers
// STREAM  | accept TILE_K vectors; a cycle with no accept feeds a bubble
// FLUSH   | feed zeros for 2*LENGTH-1 cycles so the last operands drain
// DONE    | one-cycle DONE pulse, then back to IDLE

module systolic_data_setup #(
  parameter int WIDTH   = 8,
  parameter int LENGTH  = 256,
  parameter int DEPTH_W = 16
) (
  input  logic                              CLK,
  input  logic                              ASYNC_RST,
  input  logic                              SYNC_RST,
  input  logic                              START,
  input  logic [DEPTH_W-1:0]                TILE_K,
  input  logic                              IN_VALID,
  output logic                              IN_READY,
  input  logic [0:LENGTH-1][WIDTH-1:0]      IN_VEC,
  input  logic [0:LENGTH-1][WIDTH-1:0]      W_VEC,
  output logic [0:LENGTH-1][WIDTH-1:0]      MMU_INPUTS,
  output logic [0:LENGTH-1][WIDTH-1:0]      MMU_WEIGHTS,
  output logic                              MMU_EN,
  output logic                              MMU_CLR,
  output logic                              BUSY,
  output logic                              DONE
`ifdef DATA_SETUP_STALL_CNT_EN
  ,
  output logic [DEPTH_W-1:0]                STALL_CNT
`endif
);

  localparam int FLUSH_W = (LENGTH > 1) ? $clog2(2 * LENGTH) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(2 * LENGTH - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   tile_k_q, tile_k_d;
  logic [DEPTH_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 en_q, en_d;
  logic                 clr_q, clr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 start_ok;
  logic                 accept;
  logic                 pipe_adv;
  logic                 pipe_zero;

  assign start_ok  = (state_q == S_IDLE) && START && (TILE_K != '0);
  // in_ready_q is high exactly while the FSM is in STREAM
  assign accept    = in_ready_q && IN_VALID;
  assign pipe_adv  = (state_q == S_STREAM) || (state_q == S_FLUSH);
  assign pipe_zero = SYNC_RST || (state_q == S_CLEAR);

  always_comb begin
    state_d     = state_q;
    tile_k_d    = tile_k_q;
    acc_cnt_d   = acc_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (SYNC_RST) begin
      state_d     = S_IDLE;
      tile_k_d    = '0;
      acc_cnt_d   = '0;
      flush_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            tile_k_d  = TILE_K;
            acc_cnt_d = '0;
            state_d   = S_CLEAR;
          end
        end
        S_CLEAR: state_d = S_STREAM;
        S_STREAM: begin
          if (accept) begin
            acc_cnt_d = acc_cnt_q + DEPTH_W'(1);
            if (acc_cnt_d == tile_k_q) begin
              state_d     = S_FLUSH;
              flush_cnt_d = FLUSH_LOAD;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they line up with the
    // state they describe and come straight from flops.
    in_ready_d = (state_d == S_STREAM);
    en_d       = (state_d == S_STREAM) || (state_d == S_FLUSH);
    clr_d      = (state_d == S_CLEAR);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q     <= S_IDLE;
      tile_k_q    <= '0;
      acc_cnt_q   <= '0;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_k_q    <= tile_k_d;
      acc_cnt_q   <= acc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      in_ready_q  <= in_ready_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign IN_READY = in_ready_q;
  assign MMU_EN   = en_q;
  assign MMU_CLR  = clr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

  // Lane i is a chain of i+1 registers. A cycle with no accept loads zero
  // into every lane head at once, so a bubble travels down the same
  // diagonal as real data and never pairs an input with the wrong weight.
  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    logic [WIDTH-1:0] in_q [0:i];
    logic [WIDTH-1:0] in_d [0:i];
    logic [WIDTH-1:0] w_q  [0:i];
    logic [WIDTH-1:0] w_d  [0:i];

    always_comb begin
      for (int j = 0; j <= i; j++) begin
        in_d[j] = in_q[j];
        w_d[j]  = w_q[j];
      end
      if (pipe_zero) begin
        for (int j = 0; j <= i; j++) begin
          in_d[j] = '0;
          w_d[j]  = '0;
        end
      end else if (pipe_adv) begin
        in_d[0] = accept ? IN_VEC[i] : '0;
        w_d[0]  = accept ? W_VEC[i]  : '0;
        for (int j = 1; j <= i; j++) begin
          in_d[j] = in_q[j-1];
          w_d[j]  = w_q[j-1];
        end
      end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
        in_q <= '{default: '0};
        w_q  <= '{default: '0};
      end else begin
        in_q <= in_d;
        w_q  <= w_d;
      end
    end

    assign MMU_INPUTS[i]  = in_q[i];
    assign MMU_WEIGHTS[i] = w_q[i];
  end

`ifdef DATA_SETUP_STALL_CNT_EN
  logic [DEPTH_W-1:0] stall_cnt_q, stall_cnt_d;

  // Cleared only by reset or a new tile, so the count stays readable after DONE
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (SYNC_RST || start_ok) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_STREAM) && !IN_VALID && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + DEPTH_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_data_setup.sv
module tb_systolic_data_setup;
  localparam int WIDTH     = 8;
  localparam int LENGTH    = 4;
  localparam int DEPTH_W   = 16;
  localparam int FLUSH_CYC = 2 * LENGTH - 1;

  logic                         CLK = 1'b0;
  logic                         ASYNC_RST = 1'b0;
  logic                         SYNC_RST = 1'b0;
  logic                         START = 1'b0;
  logic [DEPTH_W-1:0]           TILE_K = '0;
  logic                         IN_VALID = 1'b0;
  logic                         IN_READY;
  logic [0:LENGTH-1][WIDTH-1:0] IN_VEC = '0;
  logic [0:LENGTH-1][WIDTH-1:0] W_VEC = '0;
  logic [0:LENGTH-1][WIDTH-1:0] MMU_INPUTS;
  logic [0:LENGTH-1][WIDTH-1:0] MMU_WEIGHTS;
  logic                         MMU_EN, MMU_CLR, BUSY, DONE;
`ifdef DATA_SETUP_STALL_CNT_EN
  logic [DEPTH_W-1:0]           STALL_CNT;
`endif

  systolic_data_setup #(.WIDTH(WIDTH), .LENGTH(LENGTH), .DEPTH_W(DEPTH_W)) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .START(START),
    .TILE_K(TILE_K), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_VEC(IN_VEC), .W_VEC(W_VEC), .MMU_INPUTS(MMU_INPUTS),
    .MMU_WEIGHTS(MMU_WEIGHTS), .MMU_EN(MMU_EN), .MMU_CLR(MMU_CLR),
    .BUSY(BUSY), .DONE(DONE)
`ifdef DATA_SETUP_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Downstream output-stationary array: inputs flow right, weights flow down
  logic [7:0] a_r [0:LENGTH-1][0:LENGTH-1];
  logic [7:0] b_r [0:LENGTH-1][0:LENGTH-1];
  int         acc [0:LENGTH-1][0:LENGTH-1];

  always @(posedge CLK) begin
    for (int r = 0; r < LENGTH; r++) begin
      for (int c = 0; c < LENGTH; c++) begin
        logic [7:0] ai, bi;
        if (c == 0) ai = MMU_INPUTS[r];  else ai = a_r[r][c-1];
        if (r == 0) bi = MMU_WEIGHTS[c]; else bi = b_r[r-1][c];
        if (MMU_CLR) begin
          acc[r][c] <= 0;
          a_r[r][c] <= '0;
          b_r[r][c] <= '0;
        end else if (MMU_EN) begin
          acc[r][c] <= acc[r][c] + int'(ai) * int'(bi);
          a_r[r][c] <= ai;
          b_r[r][c] <= bi;
        end
      end
    end
  end

  typedef struct packed {
    logic [15:0][31:0] c;
    int                done_cyc;
    int                stall;
  } exp_t;

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;

  logic [7:0] in_tab [0:5][0:3];
  logic [7:0] w_tab  [0:5][0:3];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every DONE pulse pops one expected tile result
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: DONE=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        for (int r = 0; r < LENGTH; r++)
          for (int c = 0; c < LENGTH; c++)
            check($sformatf("result[%0d][%0d]", r, c), acc[r][c], e.c[r*LENGTH+c]);
`ifdef DATA_SETUP_STALL_CNT_EN
        check("stall_cnt", STALL_CNT, e.stall);
`endif
      end
    end
  end

  // Called on the negedge where START is driven
  task automatic push_exp(input int base, input int k, input int stall);
    exp_t e;
    e.c = '0;
    for (int kk = 0; kk < k; kk++)
      for (int r = 0; r < LENGTH; r++)
        for (int c = 0; c < LENGTH; c++)
          e.c[r*LENGTH+c] = e.c[r*LENGTH+c] +
                            32'(int'(in_tab[base+kk][r]) * int'(w_tab[base+kk][c]));
    e.done_cyc = cyc + 1 + 1 + (k + stall) + FLUSH_CYC;
    e.stall    = stall;
    sb.push_back(e);
  endtask

  task automatic present(input int row);
    for (int r = 0; r < LENGTH; r++) begin
      IN_VEC[r] = in_tab[row][r];
      W_VEC[r]  = w_tab[row][r];
    end
    IN_VALID = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d tiles pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic run_tile(input int base, input int k, input int stall, input bit flush_start);
    int  idx = 0;
    int  hold = 0;
    int  guard = 0;
    int  dc0;
    bit  acc_now;
    dc0 = done_count;
    @(negedge CLK);
    push_exp(base, k, stall);
    START  = 1'b1;
    TILE_K = DEPTH_W'(k);
    present(base);
    while (idx < k && guard < 100) begin
      acc_now = IN_VALID && IN_READY;
      @(negedge CLK);
      START = 1'b0;
      guard++;
      if (acc_now) begin
        idx++;
        if (idx == 1) hold = stall;
      end
      if (idx >= k) IN_VALID = 1'b0;
      else if (hold > 0) begin
        IN_VALID = 1'b0;
        IN_VEC   = $urandom();
        W_VEC    = $urandom();
        hold--;
      end else present(base + idx);
    end
    if (idx < k) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: accepted %0d expected %0d", idx, k);
    end
    IN_VALID = 1'b0;
    IN_VEC   = $urandom();
    W_VEC    = $urandom();
    if (flush_start) begin
      repeat (3) @(negedge CLK);
      START  = 1'b1;
      TILE_K = 16'd2;
      @(negedge CLK);
      START  = 1'b0;
    end
    wait_done();
    check("done_pulses", done_count - dc0, 1);
  endtask

  initial begin
    logic [0:LENGTH-1][WIDTH-1:0] ev, ew;
    int dc0;

    in_tab[0] = '{8'd1, 8'd2, 8'd3, 8'd4};     w_tab[0] = '{8'd5, 8'd6, 8'd7, 8'd8};
    in_tab[1] = '{8'd3, 8'd0, 8'd7, 8'd2};     w_tab[1] = '{8'd1, 8'd4, 8'd2, 8'd9};
    in_tab[2] = '{8'd5, 8'd1, 8'd0, 8'd6};     w_tab[2] = '{8'd2, 8'd3, 8'd8, 8'd1};
    in_tab[3] = '{8'd255, 8'd4, 8'd9, 8'd1};   w_tab[3] = '{8'd255, 8'd2, 8'd5, 8'd7};
    in_tab[4] = '{8'd6, 8'd8, 8'd1, 8'd200};   w_tab[4] = '{8'd3, 8'd0, 8'd6, 8'd250};
    in_tab[5] = '{8'd2, 8'd9, 8'd4, 8'd3};     w_tab[5] = '{8'd7, 8'd1, 8'd3, 8'd2};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_in_ready", IN_READY, 0);
    check("rst_en", MMU_EN, 0);
    check("rst_clr", MMU_CLR, 0);
    check("rst_done", DONE, 0);
    check("rst_inputs", MMU_INPUTS, 0);
    check("rst_weights", MMU_WEIGHTS, 0);
    ASYNC_RST = 1'b1;
    @(negedge CLK);
    check("idle_busy", BUSY, 0);

    // Skew: single vector, lane j appears j cycles after lane 0
    @(negedge CLK);
    push_exp(0, 1, 0);
    START = 1'b1;
    TILE_K = 16'd1;
    present(0);
    @(negedge CLK);
    START = 1'b0;
    check("clear_clr", MMU_CLR, 1);
    check("clear_en", MMU_EN, 0);
    check("clear_busy", BUSY, 1);
    check("clear_in_ready", IN_READY, 0);
    @(negedge CLK);
    check("stream_in_ready", IN_READY, 1);
    check("stream_en", MMU_EN, 1);
    check("stream_clr", MMU_CLR, 0);
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_VEC = 32'hAAAA_AAAA;
    W_VEC  = 32'h5555_5555;
    check("flush_in_ready", IN_READY, 0);
    for (int j = 0; j < LENGTH; j++) begin
      ev = '0;
      ew = '0;
      ev[j] = in_tab[0][j];
      ew[j] = w_tab[0][j];
      check($sformatf("skew_inputs_t%0d", j), MMU_INPUTS, ev);
      check($sformatf("skew_weights_t%0d", j), MMU_WEIGHTS, ew);
      @(negedge CLK);
    end
    wait_done();

    // Full tile, continuous valid
    run_tile(1, 3, 0, 1'b0);
    // Same tile with a two-cycle gap after the first accept
    run_tile(1, 3, 2, 1'b0);

    // START with TILE_K=0 is ignored
    dc0 = done_count;
    @(negedge CLK);
    START = 1'b1;
    TILE_K = 16'd0;
    @(negedge CLK);
    START = 1'b0;
    check("k0_busy", BUSY, 0);
    repeat (15) @(negedge CLK);
    check("k0_no_done", done_count - dc0, 0);

    // START pulse during FLUSH has no effect
    run_tile(3, 3, 0, 1'b1);

    // Async reset mid-stream
    dc0 = done_count;
    @(negedge CLK);
    START = 1'b1;
    TILE_K = 16'd3;
    IN_VALID = 1'b1;
    IN_VEC = $urandom();
    W_VEC = $urandom();
    @(negedge CLK);
    START = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      IN_VEC = $urandom();
      W_VEC = $urandom();
    end
    #2 ASYNC_RST = 1'b0;
    #1;
    check("arst_busy", BUSY, 0);
    check("arst_en", MMU_EN, 0);
    check("arst_in_ready", IN_READY, 0);
    check("arst_inputs", MMU_INPUTS, 0);
    check("arst_weights", MMU_WEIGHTS, 0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    ASYNC_RST = 1'b1;
    @(negedge CLK);
    check("arst_rel_busy", BUSY, 0);
    check("arst_rel_in_ready", IN_READY, 0);
    repeat (15) @(negedge CLK);
    check("arst_no_done", done_count - dc0, 0);

    // SYNC_RST during STREAM
    dc0 = done_count;
    @(negedge CLK);
    START = 1'b1;
    TILE_K = 16'd3;
    present(4);
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    SYNC_RST = 1'b1;
    @(negedge CLK);
    SYNC_RST = 1'b0;
    IN_VALID = 1'b0;
    check("srst_busy", BUSY, 0);
    check("srst_in_ready", IN_READY, 0);
    check("srst_en", MMU_EN, 0);
    check("srst_inputs", MMU_INPUTS, 0);
    check("srst_weights", MMU_WEIGHTS, 0);
`ifdef DATA_SETUP_STALL_CNT_EN
    check("srst_stall_cnt", STALL_CNT, 0);
`endif
    repeat (15) @(negedge CLK);
    check("srst_no_done", done_count - dc0, 0);

    // Clean tile after the abort
    run_tile(4, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
